// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per enabled cycle on operand magnitudes,
// with sign fix-up, divide-by-zero and signed-overflow handling on entry to FIN.
module seq_divider #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned SIGNED = 1
) (
  input  logic             CLK,
  input  logic             SCLR,
  input  logic             CE,
  input  logic             START,
  input  logic [WIDTH-1:0] DIVIDEND,
  input  logic [WIDTH-1:0] DIVISOR,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] QUOTIENT,
  output logic [WIDTH-1:0] FRACTIONAL,
  output logic             DIV_BY_ZERO
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

  state_e           state;
  logic [CntW-1:0]  cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             q_neg;
  logic             r_neg;

  logic             neg_a, neg_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   shifted, diff;
  logic             take;
  logic [WIDTH-1:0] rem_nxt, quo_nxt, fin_q, fin_r;

  always_comb begin
    neg_a   = (SIGNED != 0) && DIVIDEND[WIDTH-1];
    neg_b   = (SIGNED != 0) && DIVISOR[WIDTH-1];
    mag_a   = neg_a ? -DIVIDEND : DIVIDEND;
    mag_b   = neg_b ? -DIVISOR : DIVISOR;
    // Partial remainder stays below the divisor, so the borrow bit alone decides the step.
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
    take    = ~diff[WIDTH];
    rem_nxt = take ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_nxt = {quo[WIDTH-2:0], take};
    fin_q   = q_neg ? -quo_nxt : quo_nxt;
    fin_r   = r_neg ? -rem_nxt : rem_nxt;
  end

  always_ff @(posedge CLK or posedge SCLR) begin
    if (SCLR) begin
      state       <= StIdle;
      cnt         <= '0;
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      QUOTIENT    <= '0;
      FRACTIONAL  <= '0;
      DIV_BY_ZERO <= 1'b0;
    end else if (CE) begin
      case (state)
        StIdle, StFin: begin
          if (START) begin
            if (DIVISOR == '0) begin
              state       <= StFin;
              DONE        <= 1'b1;
              QUOTIENT    <= '1;
              FRACTIONAL  <= DIVIDEND;
              DIV_BY_ZERO <= 1'b1;
            end else begin
              state <= StCalc;
              BUSY  <= 1'b1;
              DONE  <= 1'b0;
              cnt   <= '0;
              rem   <= '0;
              quo   <= mag_a;
              dvs   <= mag_b;
              q_neg <= neg_a ^ neg_b;
              r_neg <= neg_a;
            end
          end else begin
            state <= StIdle;
            DONE  <= 1'b0;
          end
        end
        StCalc: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CntW'(WIDTH - 1)) begin
            state       <= StFin;
            BUSY        <= 1'b0;
            DONE        <= 1'b1;
            QUOTIENT    <= fin_q;
            FRACTIONAL  <= fin_r;
            DIV_BY_ZERO <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: a 32-bit signed and an 8-bit unsigned instance,
// directed scenarios plus random operands checked against plain HDL arithmetic.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        sclr, ce;
  logic        start, busy, done, dbz;
  logic [31:0] dividend, divisor, quotient, fractional;
  logic        start8, busy8, done8, dbz8;
  logic [7:0]  dividend8, divisor8, quot8, frac8;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(32), .SIGNED(1)) u_dut32 (
    .CLK(clk), .SCLR(sclr), .CE(ce), .START(start), .DIVIDEND(dividend), .DIVISOR(divisor),
    .BUSY(busy), .DONE(done), .QUOTIENT(quotient), .FRACTIONAL(fractional), .DIV_BY_ZERO(dbz)
  );

  seq_divider #(.WIDTH(8), .SIGNED(0)) u_dut8 (
    .CLK(clk), .SCLR(sclr), .CE(ce), .START(start8), .DIVIDEND(dividend8), .DIVISOR(divisor8),
    .BUSY(busy8), .DONE(done8), .QUOTIENT(quot8), .FRACTIONAL(frac8), .DIV_BY_ZERO(dbz8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Signed reference: HDL / and % with the two special cases handled up front.
  task automatic model32(input logic [31:0] a, input logic [31:0] b, output logic [31:0] q,
                         output logic [31:0] r, output logic z);
    z = 1'b0;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; z = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
  endtask

  // Issue one 32-bit division and wait (bounded) for DONE; scrambles operands after accept.
  task automatic run32(input logic [31:0] a, input logic [31:0] b, output int cyc,
                       output int nbusy, output logic [31:0] q, output logic [31:0] r,
                       output logic z);
    start = 1'b1; dividend = a; divisor = b;
    tick();
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    cyc = 1; nbusy = 0;
    while (!done && cyc < 200) begin
      if (busy) nbusy++;
      tick();
      cyc++;
    end
    q = quotient; r = fractional; z = dbz;
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, output int cyc,
                      output logic [7:0] q, output logic [7:0] r);
    start8 = 1'b1; dividend8 = a; divisor8 = b;
    tick();
    start8 = 1'b0; dividend8 = 8'($urandom); divisor8 = 8'($urandom);
    cyc = 1;
    while (!done8 && cyc < 100) begin
      tick();
      cyc++;
    end
    q = quot8; r = frac8;
  endtask

  task automatic test_reset();
    sclr = 1'b1; ce = 1'b1; start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    start8 = 1'b1; dividend8 = 8'd9; divisor8 = 8'd2;
    tick(); tick();
    n_checks++;
    if ({busy, done, quotient, fractional, dbz} !== 67'd0) begin
      n_fails++;
      $display("FAIL reset32: got busy=%b done=%b q=%h r=%h z=%b required all zero",
               busy, done, quotient, fractional, dbz);
    end
    n_checks++;
    if ({busy8, done8, quot8, frac8, dbz8} !== 19'd0) begin
      n_fails++;
      $display("FAIL reset8: got busy=%b done=%b q=%h r=%h z=%b required all zero",
               busy8, done8, quot8, frac8, dbz8);
    end
    start = 1'b0; start8 = 1'b0;
    sclr = 1'b0;
  endtask

  task automatic test_basic();
    int cyc, nb;
    logic [31:0] q, r;
    logic z;
    run32(32'd100, 32'd7, cyc, nb, q, r, z);
    n_checks++;
    if (nb !== 32 || cyc !== 33) begin
      n_fails++;
      $display("FAIL basic_timing: got busy=%0d done_cycle=%0d required 32 33", nb, cyc);
    end
    n_checks++;
    if (q !== 32'd14 || r !== 32'd2 || z !== 1'b0) begin
      n_fails++;
      $display("FAIL basic_100_7: got q=%0d r=%0d z=%b required 14 2 0", q, r, z);
    end
    // Accepted straight from FIN; old result must hold while the new one is computed.
    start = 1'b1; dividend = -32'sd100; divisor = 32'd7;
    tick();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || quotient !== 32'd14) begin
      n_fails++;
      $display("FAIL back_to_back_accept: got busy=%b q=%0d required 1 14", busy, quotient);
    end
    cyc = 1;
    while (!done && cyc < 200) begin tick(); cyc++; end
    n_checks++;
    if (cyc !== 33 || quotient !== -32'sd14 || fractional !== -32'sd2) begin
      n_fails++;
      $display("FAIL basic_neg: got cyc=%0d q=%0d r=%0d required 33 -14 -2",
               cyc, $signed(quotient), $signed(fractional));
    end
  endtask

  task automatic test_special();
    int cyc, nb;
    logic [31:0] q, r;
    logic z;
    run32(32'h8000_0000, 32'hFFFF_FFFF, cyc, nb, q, r, z);
    n_checks++;
    if (cyc !== 33 || q !== 32'h8000_0000 || r !== 32'd0 || z !== 1'b0) begin
      n_fails++;
      $display("FAIL overflow: got cyc=%0d q=%h r=%h z=%b required 33 80000000 0 0",
               cyc, q, r, z);
    end
    run32(32'd5, 32'd0, cyc, nb, q, r, z);
    n_checks++;
    if (cyc !== 1 || nb !== 0 || q !== 32'hFFFF_FFFF || r !== 32'd5 || z !== 1'b1) begin
      n_fails++;
      $display("FAIL div_zero: got cyc=%0d q=%h r=%h z=%b required 1 ffffffff 5 1", cyc, q, r, z);
    end
    run32(-32'sd9, 32'd4, cyc, nb, q, r, z);
    n_checks++;
    if (z !== 1'b0 || q !== -32'sd2 || r !== -32'sd1) begin
      n_fails++;
      $display("FAIL dbz_clear: got q=%0d r=%0d z=%b required -2 -1 0",
               $signed(q), $signed(r), z);
    end
  endtask

  task automatic test_abort();
    int cyc, nb;
    int seen;
    logic [31:0] q, r;
    logic z;
    run32(32'd7, 32'd0, cyc, nb, q, r, z);
    start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
    tick();
    start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    #2 sclr = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, quotient, fractional, dbz} !== 67'd0) begin
      n_fails++;
      $display("FAIL async_abort: got busy=%b done=%b q=%h r=%h z=%b required all zero",
               busy, done, quotient, fractional, dbz);
    end
    #1 sclr = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fails++;
      $display("FAIL abort_no_done: got %0d active cycles required 0", seen);
    end
    run32(32'd1000, 32'd3, cyc, nb, q, r, z);
    n_checks++;
    if (cyc !== 33 || q !== 32'd333 || r !== 32'd1) begin
      n_fails++;
      $display("FAIL after_abort: got cyc=%0d q=%0d r=%0d required 33 333 1", cyc, q, r);
    end
  endtask

  task automatic test_ce_stall();
    int cyc;
    logic [31:0] q_hold;
    start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 200) begin
      ce = (cyc >= 5 && cyc <= 9) ? 1'b0 : 1'b1;
      start = (cyc == 3 || cyc == 4);
      dividend = 32'd55; divisor = 32'd5;
      tick();
      cyc++;
    end
    ce = 1'b1; start = 1'b0;
    n_checks++;
    if (cyc !== 38 || quotient !== 32'd14 || fractional !== 32'd2) begin
      n_fails++;
      $display("FAIL ce_stall: got cyc=%0d q=%0d r=%0d required 38 14 2", cyc, quotient, fractional);
    end
    q_hold = quotient;
    ce = 1'b0;
    tick(); tick(); tick();
    n_checks++;
    if (done !== 1'b1 || quotient !== q_hold) begin
      n_fails++;
      $display("FAIL ce_hold_done: got done=%b q=%0d required 1 %0d", done, quotient, q_hold);
    end
    ce = 1'b1;
    tick(); tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fails++;
      $display("FAIL start_not_queued: got done=%b busy=%b required 0 0", done, busy);
    end
  endtask

  task automatic test_random32();
    int cyc, nb, want_cyc;
    logic [31:0] a, b, q, r, eq, er;
    logic z, ez;
    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: b = -32'($urandom_range(1, 15));
        4: b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if (b != 32'd0) b = b;
      model32(a, b, eq, er, ez);
      want_cyc = (b == 32'd0) ? 1 : 33;
      run32(a, b, cyc, nb, q, r, z);
      n_checks++;
      if (cyc !== want_cyc || q !== eq || r !== er || z !== ez) begin
        n_fails++;
        $display("FAIL random32 %h/%h: got cyc=%0d q=%h r=%h z=%b required %0d %h %h %b",
                 a, b, cyc, q, r, z, want_cyc, eq, er, ez);
      end
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < $urandom_range(1, 3); i++) tick();
      end
    end
  endtask

  task automatic test_unsigned8();
    int cyc;
    logic [7:0] a, b, q, r;
    run8(8'd200, 8'd3, cyc, q, r);
    n_checks++;
    if (cyc !== 9 || q !== 8'd66 || r !== 8'd2) begin
      n_fails++;
      $display("FAIL u8_200_3: got cyc=%0d q=%0d r=%0d required 9 66 2", cyc, q, r);
    end
    run8(8'd255, 8'd255, cyc, q, r);
    n_checks++;
    if (cyc !== 9 || q !== 8'd1 || r !== 8'd0) begin
      n_fails++;
      $display("FAIL u8_255_255: got cyc=%0d q=%0d r=%0d required 9 1 0", cyc, q, r);
    end
    for (int n = 0; n < 20; n++) begin
      a = 8'($urandom);
      b = 8'($urandom_range(1, 255));
      run8(a, b, cyc, q, r);
      n_checks++;
      if (cyc !== 9 || q !== a / b || r !== a % b || dbz8 !== 1'b0) begin
        n_fails++;
        $display("FAIL random8 %0d/%0d: got cyc=%0d q=%0d r=%0d required 9 %0d %0d",
                 a, b, cyc, q, r, a / b, a % b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_special();
    test_abort();
    test_ce_stall();
    test_random32();
    test_unsigned8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
